// File: rtl/mem_copy8_if.sv
// Control and memory-bus signals of the mem_copy8 byte copier.
// The copier connects to the slave modport; the environment drives the master side.
interface mem_copy8_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [7:0]    len;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic          mem_r_w;
  logic [AW-1:0] mem_abus;
  logic [DW-1:0] mem_dbus_out;
  logic [DW-1:0] mem_dbus_in;

  modport slave (
    input  start, src, dst, len, mem_dbus_in,
    output busy, done, mem_en, mem_r_w, mem_abus, mem_dbus_out
  );

  modport master (
    output start, src, dst, len, mem_dbus_in,
    input  busy, done, mem_en, mem_r_w, mem_abus, mem_dbus_out
  );
endinterface

// File: rtl/mem_copy8.sv
// Byte-by-byte memory copier: read src+i, capture, write dst+i, three cycles per byte,
// through a registered single-port memory. All outputs come straight from flops.
module mem_copy8 #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic       clock,
  input  logic       reset,
  mem_copy8_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    i_q, i_d;
  logic [7:0]    i_inc;
  logic [DW-1:0] buf_q, buf_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_r_w_q, mem_r_w_d;
  logic [AW-1:0] mem_abus_q, mem_abus_d;
  logic [DW-1:0] mem_dbus_out_q, mem_dbus_out_d;

  assign i_inc = i_q + 8'd1;

  always_comb begin : next_state
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    i_d     = i_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != 8'd0) begin
            src_d   = bus.src;
            dst_d   = bus.dst;
            len_d   = bus.len;
            i_d     = '0;
            state_d = RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD:   state_d = CAP;
      CAP: begin
        buf_d   = bus.mem_dbus_in;
        state_d = WR;
      end
      WR: begin
        // Compare against i+1 before i is committed, so len=255 never wraps i.
        i_d     = i_inc;
        state_d = (i_inc == len_q) ? DONE : RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each flop shows the
  // value belonging to the state being entered without any input-to-output path.
  always_comb begin : output_decode
    busy_d         = (state_d == RD) || (state_d == CAP) || (state_d == WR);
    done_d         = (state_d == DONE);
    mem_en_d       = (state_d == RD) || (state_d == WR);
    mem_r_w_d      = (state_d != WR);
    mem_abus_d     = mem_abus_q;
    mem_dbus_out_d = mem_dbus_out_q;
    if (state_d == RD) begin
      mem_abus_d = src_d + AW'(i_d);
    end else if (state_d == WR) begin
      mem_abus_d     = dst_d + AW'(i_d);
      mem_dbus_out_d = buf_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      i_q            <= '0;
      buf_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mem_en_q       <= 1'b0;
      mem_r_w_q      <= 1'b1;
      mem_abus_q     <= '0;
      mem_dbus_out_q <= '0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      len_q          <= len_d;
      i_q            <= i_d;
      buf_q          <= buf_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mem_en_q       <= mem_en_d;
      mem_r_w_q      <= mem_r_w_d;
      mem_abus_q     <= mem_abus_d;
      mem_dbus_out_q <= mem_dbus_out_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_r_w      = mem_r_w_q;
  assign bus.mem_abus     = mem_abus_q;
  assign bus.mem_dbus_out = mem_dbus_out_q;

endmodule
